audio_request_arbiter: RTL
==========================

# audio_request_arbiter

Collects one-cycle sound-event requests from game logic (play, level, world, life, win, lose), holds them as pending, and issues them one at a time to the audio sequencer through its `enable`/`audioSelect`/`seqEnd` handshake. Sits between the game FSM and the sequencer; it is the only driver of the sequencer's `enable` and `audioSelect`. Priority is fixed, duplicate requests coalesce, and an optional watchdog recovers from a sequencer that never reports end.

## Interface
- `NUM_SOUNDS`, 7: request vector width; sound codes 0..6.
- `GAP_CYCLES`, 16: silent clocks between end of one sound and issue of the next; 0 allowed.
- `TIMEOUT_CYCLES`, 2^24: watchdog limit in WAIT; only used with the watchdog macro.
- `clk` in 1: clock, rising edge.
- `reset` in 1: reset, asynchronous, active-high.
- `req` in NUM_SOUNDS: request pulses; bit i requests sound code i.
- `flush` in 1: synchronous clear of all pending requests.
- `seq_end` in 1: sequencer end-of-sequence pulse.
- `seq_enable` out 1: one-cycle start strobe to the sequencer.
- `seq_select` out 3: sound code to the sequencer; stable from ISSUE through WAIT.
- `busy` out 1: high whenever state is not IDLE.
- `pending` out NUM_SOUNDS: registered pending vector.
- `timeout` out 1: one-cycle pulse on watchdog expiry.

## Operation
- Pending register: `pending[i]` sets on `req[i]`. Repeated requests while set coalesce. The bit clears on grant. If a request arrives in the same cycle as the grant of that bit, set wins and the sound replays later. `flush` clears every bit and overrides same-cycle `req`.
- Priority: highest pending index wins. Order is lose(6) > win(5) > life(4) > world(3) > level(2) > 1 > 0.
- FSM states:
  - IDLE: if `pending` != 0, register the winner into `seq_select`, clear its bit, go to ISSUE.
  - ISSUE: `seq_enable`=1 for exactly this cycle; go to WAIT.
  - WAIT: on `seq_end`, go to GAP, or to IDLE if GAP_CYCLES=0.
  - GAP: count GAP_CYCLES clocks, then go to IDLE.
- `seq_end` outside WAIT is ignored.
- A running sound is never aborted. Higher-priority requests wait in `pending`.
- `flush` does not affect the active sound or the FSM.
- `seq_select` holds its last value in GAP and IDLE. It changes only on grant.
- Counters: the gap counter is $clog2(GAP_CYCLES+1) bits wide; the watchdog counter is $clog2(TIMEOUT_CYCLES) bits wide. Both clear on every state entry and saturate, never wrap.

## Timing
- All outputs are registered.
- Reset values:
  - state = IDLE
  - `seq_enable`, `busy`, `timeout` = 0
  - `seq_select` = 0
  - `pending` = 0
  - counters = 0
- Reset mid-sound drops the active sound and all pending requests immediately.
- Latency: `req` sampled at edge N sets `pending` at N. IDLE grants at edge N+1. `seq_enable` is high in cycle N+1..N+2.
- Back-to-back: `seq_end` sampled at edge M gives the next `seq_enable` in cycle M+GAP_CYCLES+2.
- `busy` rises with ISSUE and falls on return to IDLE.

## Configuration
- `AUDIO_ARB_WATCHDOG_EN` defined:
  - WAIT counts cycles. If TIMEOUT_CYCLES clocks pass without `seq_end`, `timeout` pulses for one cycle and the FSM goes to GAP.
  - `seq_end` in the expiry cycle takes precedence and `timeout` stays 0.
- Undefined: WAIT waits indefinitely, `timeout` is tied 0, and no watchdog counter is built.

## Structure
- Shared package `audio_pkg`:
  - sound code constants SND_PLAY=0, SND_LEVEL=2, SND_WORLD=3, SND_LIFE=4, SND_WIN=5, SND_LOSE=6
  - arbiter state encodings IDLE/ISSUE/WAIT/GAP
  - the 3-bit code width
- One sub-module, `audio_prio_enc`: combinational highest-index priority encoder, NUM_SOUNDS to 3-bit code plus valid.

## Test plan
- Single request: `req`=0b0000100 at cycle 5 -> `seq_enable` high cycle 7 with `seq_select`=2. `busy` holds until `seq_end`+GAP, then `pending`=0.
- Simultaneous requests: `req`=0b1010100 -> issue order 6, 4, 2. Each `seq_enable` is spaced GAP_CYCLES+2 after its predecessor's `seq_end`.
- Coalesce and replay: `req[3]` pulsed 3 times during WAIT -> played once. A `req[3]` coinciding with its grant cycle -> played twice.
- Flush: pend 0b0110000 during WAIT, assert `flush` -> current sound completes, no further `seq_enable`, `pending`=0.
- Watchdog (macro on, TIMEOUT_CYCLES=100): withhold `seq_end` -> `timeout` pulses 100 cycles after WAIT entry, then the next pending sound issues. With the macro off, the FSM stays in WAIT.
- Reset during WAIT with `pending`=0b0001000 -> all outputs 0 and IDLE. No `seq_enable` after release until a new `req`.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio definitions: sound codes, arbiter state encoding, and code width.
package audio_pkg;

  localparam int CODE_W = 3;

  localparam logic [CODE_W-1:0] SND_PLAY  = 3'd0;
  localparam logic [CODE_W-1:0] SND_LEVEL = 3'd2;
  localparam logic [CODE_W-1:0] SND_WORLD = 3'd3;
  localparam logic [CODE_W-1:0] SND_LIFE  = 3'd4;
  localparam logic [CODE_W-1:0] SND_WIN   = 3'd5;
  localparam logic [CODE_W-1:0] SND_LOSE  = 3'd6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/audio_prio_enc.sv
// Combinational highest-index-wins priority encoder; zero latency, no flow control.
module audio_prio_enc
  import audio_pkg::*;
#(
  parameter int NUM_SOUNDS = 7
) (
  input  logic [NUM_SOUNDS-1:0] req_vec,
  output logic [CODE_W-1:0]     code,
  output logic                  vld
);

  // Ascending scan: the last set bit seen is the highest index, which wins.
  always_comb begin
    code = '0;
    vld  = 1'b0;
    for (int i = 0; i < NUM_SOUNDS; i++) begin
      if (req_vec[i]) begin
        code = CODE_W'(i);
        vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/audio_request_arbiter.sv
// Pends one-cycle sound requests and issues them one at a time to the sequencer; grant 1 clk after pend, enable lasts 1 clk.
// A busy sequencer holds new requests in pending (coalesced); AUDIO_ARB_WATCHDOG_EN adds a WAIT-state timeout.
module audio_request_arbiter
  import audio_pkg::*;
#(
  parameter int NUM_SOUNDS     = 7,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1 << 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_SOUNDS-1:0] req,
  input  logic                  flush,
  input  logic                  seq_end,
  output logic                  seq_enable,
  output logic [CODE_W-1:0]     seq_select,
  output logic                  busy,
  output logic [NUM_SOUNDS-1:0] pending,
  output logic                  timeout
);

  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  // With no gap, end of sound returns straight to IDLE.
  localparam arb_state_t POST_END = (GAP_CYCLES == 0) ? IDLE : GAP;

  arb_state_t            state;
  logic [GW-1:0]         gap_cnt;
  logic [CODE_W-1:0]     win_code;
  logic                  win_vld;
  logic [NUM_SOUNDS-1:0] grant_mask;
  logic [NUM_SOUNDS-1:0] pend_next;

  audio_prio_enc #(.NUM_SOUNDS(NUM_SOUNDS)) u_prio (
    .req_vec (pending),
    .code    (win_code),
    .vld     (win_vld)
  );

  // New requests OR in after the grant clear, so a same-cycle request replays.
  always_comb begin
    grant_mask = '0;
    if (state == IDLE && win_vld) grant_mask = NUM_SOUNDS'(1) << win_code;
    pend_next = (pending & ~grant_mask) | req;
    if (flush) pend_next = '0;
  end

`ifdef AUDIO_ARB_WATCHDOG_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      seq_enable <= 1'b0;
      seq_select <= '0;
      busy       <= 1'b0;
      pending    <= '0;
      gap_cnt    <= '0;
`ifdef AUDIO_ARB_WATCHDOG_EN
      wd_cnt     <= '0;
      timeout    <= 1'b0;
`endif
    end else begin
      seq_enable <= 1'b0;
      pending    <= pend_next;
      gap_cnt    <= '0;
`ifdef AUDIO_ARB_WATCHDOG_EN
      wd_cnt     <= '0;
      timeout    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (win_vld) begin
            seq_select <= win_code;
            seq_enable <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (seq_end) begin
            state <= POST_END;
            busy  <= (POST_END != IDLE);
          end
`ifdef AUDIO_ARB_WATCHDOG_EN
          else if (wd_cnt == WD_LAST) begin
            timeout <= 1'b1;
            state   <= POST_END;
            busy    <= (POST_END != IDLE);
          end else begin
            wd_cnt <= (wd_cnt == '1) ? wd_cnt : wd_cnt + 1'b1;
          end
`endif
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= (gap_cnt == '1) ? gap_cnt : gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
